// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch FIFO between memory and decode.
// Optional FETCH_BYPASS_EN: an ack into an empty queue issues directly, skipping the FIFO.
module instruction_fetch_queue #(
  parameter int                I_WIDTH  = 32,
  parameter int                A_WIDTH  = 32,
  parameter int                PC_WIDTH = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       f_clk,
  input  logic                       f_rst,
  output logic                       o_syn,
  output logic [A_WIDTH-1:0]         o_addr_instr,
  input  logic                       i_ack,
  input  logic [I_WIDTH-1:0]         i_instr,
  input  logic                       change_pc,
  input  logic [PC_WIDTH-1:0]        alu_pc_value,
  input  logic                       i_stall,
  output logic [I_WIDTH-1:0]         o_instr,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       o_ce,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nx;
  logic [PC_WIDTH-1:0] target, target_nx;
  logic [CW-1:0]       count, count_nx;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop, bypass;

  logic [I_WIDTH-1:0]  mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pop = (count != '0) && !i_stall && !change_pc;
`ifdef FETCH_BYPASS_EN
    bypass = (state == REQ) && i_ack && (count == '0) && !i_stall && !change_pc;
`else
    bypass = 1'b0;
`endif
    push     = (state == REQ) && i_ack && !change_pc && !bypass;
    count_nx = change_pc ? '0 : count + CW'(push) - CW'(pop);

    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    target_nx   = target;
    case (state)
      IDLE: begin
        if (change_pc)              fetch_pc_nx = alu_pc_value;
        else if (count < DEPTH_C)   state_nx    = REQ;
      end
      REQ: begin
        if (i_ack) begin
          fetch_pc_nx = change_pc ? alu_pc_value : fetch_pc + PC_WIDTH'(PC_STEP);
          state_nx    = (change_pc || count_nx < DEPTH_C) ? REQ : IDLE;
        end else if (change_pc) begin
          // The outstanding request must still complete; its data is thrown away in DROP.
          state_nx  = DROP;
          target_nx = alu_pc_value;
        end
      end
      DROP: begin
        if (change_pc) target_nx = alu_pc_value;
        if (i_ack) begin
          fetch_pc_nx = change_pc ? alu_pc_value : target;
          state_nx    = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      target   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_ce     <= 1'b0;
      o_instr  <= '0;
      pc       <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      target   <= target_nx;
      count    <= count_nx;
      if (change_pc) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      o_ce <= pop || bypass;
      if (bypass) begin
        o_instr <= i_instr;
        pc      <= fetch_pc;
      end else if (pop) begin
        o_instr <= mem_instr[rd_ptr];
        pc      <= mem_pc[rd_ptr];
      end
    end
  end

  // NOTE: FIFO storage has no reset; occupancy and pointers alone decide which entries are valid.
  always_ff @(posedge f_clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= i_instr;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

  assign o_syn        = (state != IDLE);
  assign o_addr_instr = A_WIDTH'(fetch_pc);
  assign o_count      = count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        f_clk, f_rst;
  logic        o_syn, i_ack, change_pc, i_stall, o_ce;
  logic [31:0] o_addr_instr, i_instr, alu_pc_value, o_instr, pc;
  logic [2:0]  o_count;

  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
    .f_clk(f_clk), .f_rst(f_rst), .o_syn(o_syn), .o_addr_instr(o_addr_instr),
    .i_ack(i_ack), .i_instr(i_instr), .change_pc(change_pc), .alu_pc_value(alu_pc_value),
    .i_stall(i_stall), .o_instr(o_instr), .pc(pc), .o_ce(o_ce), .o_count(o_count)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    case (a)
      32'h0000_0000: instr_for = 32'hA0A0A0A0;
      32'h0000_0004: instr_for = 32'hB1B1B1B1;
      32'h0000_0008: instr_for = 32'hC2C2C2C2;
      32'h0000_0100: instr_for = 32'hD3D3D3D3;
      default:       instr_for = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {logic [31:0] ins; logic [31:0] pc;} ent_t;
  ent_t        q[$];
  bit          m_busy, m_drop, m_ce;
  logic [31:0] m_fpc, m_tgt, m_instr, m_pc;

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_drop = 0; m_ce = 0;
    m_fpc = 0; m_tgt = 0; m_instr = 0; m_pc = 0;
  endtask

  task automatic model_step();
    int   n0;
    bit   ack, byp;
    ent_t e;
    n0  = q.size();
    ack = m_busy && i_ack;
    byp = BYP && m_busy && !m_drop && i_ack && n0 == 0 && !i_stall && !change_pc;
    m_ce = 0;
    if (!change_pc && !i_stall && n0 > 0) begin
      e = q.pop_front();
      m_ce = 1; m_instr = e.ins; m_pc = e.pc;
    end else if (byp) begin
      m_ce = 1; m_instr = i_instr; m_pc = m_fpc;
    end
    if (change_pc) q.delete();
    else if (ack && !m_drop && !byp) q.push_back('{ins: i_instr, pc: m_fpc});
    if (!m_busy) begin
      if (change_pc) m_fpc = alu_pc_value;
      else if (n0 < DEPTH) m_busy = 1;
    end else if (m_drop) begin
      if (change_pc) m_tgt = alu_pc_value;
      if (ack) begin m_fpc = change_pc ? alu_pc_value : m_tgt; m_drop = 0; end
    end else if (change_pc) begin
      if (ack) m_fpc = alu_pc_value;
      else begin m_drop = 1; m_tgt = alu_pc_value; end
    end else if (ack) begin
      m_fpc  = m_fpc + 32'd4;
      m_busy = (q.size() < DEPTH);
    end
  endtask

  always @(posedge f_clk or posedge f_rst) begin
    if (f_rst) model_reset();
    else       model_step();
  end

  int cyc;
  always @(posedge f_clk or posedge f_rst) begin
    if (f_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- per-cycle compare and issue log ----------------
  bit          chk_en = 0;
  ent_t        iss_log[$];
  int          iss_cyc[$];
  logic [31:0] acc_log[$];
  int          first_ce_cyc;

  always @(negedge f_clk) begin
    if (chk_en && !f_rst) begin
      check("o_syn",   o_syn,        m_busy);
      check("o_addr",  o_addr_instr, m_fpc);
      check("o_count", o_count,      q.size());
      check("o_ce",    o_ce,         m_ce);
      check("o_instr", o_instr,      m_instr);
      check("pc",      pc,           m_pc);
      if (o_ce) begin
        iss_log.push_back('{ins: o_instr, pc: pc});
        iss_cyc.push_back(cyc);
        if (first_ce_cyc < 0) first_ce_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  int ack_lat, age;
  bit spurious;

  task automatic tick(input logic st, input logic ch, input logic [31:0] tgt);
    @(negedge f_clk);
    i_stall      = st;
    change_pc    = ch;
    alu_pc_value = tgt;
    i_ack        = o_syn ? (age >= ack_lat) : spurious;
    i_instr      = instr_for(o_addr_instr);
    if (o_syn && i_ack) begin
      acc_log.push_back(o_addr_instr);
      age = 0;
    end else if (o_syn) age++;
    else age = 0;
  endtask

  task automatic clear_logs();
    acc_log.delete(); iss_log.delete(); iss_cyc.delete();
    first_ce_cyc = -1; age = 0; spurious = 0; ack_lat = 0;
  endtask

  task automatic do_reset();
    f_rst = 1'b1;
    i_ack = 0; change_pc = 0; i_stall = 0; alu_pc_value = 0; i_instr = 0;
    clear_logs();
    repeat (2) @(negedge f_clk);
    f_rst  = 1'b0;
    chk_en = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values and in-order back-to-back fetch.
    do_reset();
    check("rst_syn",   o_syn, 0);
    check("rst_addr",  o_addr_instr, 0);
    check("rst_count", o_count, 0);
    repeat (8) tick(0, 0, 0);
    check("t1_addr0", acc_log[0], 32'h0);
    check("t1_addr1", acc_log[1], 32'h4);
    check("t1_addr2", acc_log[2], 32'h8);
    check("t1_iss0",  iss_log[0], {32'hA0A0A0A0, 32'h0});
    check("t1_iss1",  iss_log[1], {32'hB1B1B1B1, 32'h4});
    check("t1_iss2",  iss_log[2], {32'hC2C2C2C2, 32'h8});
    check("t1_latency", first_ce_cyc, BYP ? 2 : 3);

    // Stall fills the queue; spurious acks while idle are ignored.
    do_reset();
    spurious = 1;
    repeat (6) tick(1, 0, 0);
    check("t2_full_count", o_count, 4);
    check("t2_full_syn",   o_syn, 0);
    check("t2_acc_n",      acc_log.size(), 4);
    check("t2_last_addr",  acc_log[3], 32'hC);
    spurious = 0;
    repeat (10) tick(0, 0, 0);
    check("t2_iss0", iss_log[0].pc, 32'h0);
    check("t2_iss1", iss_log[1].pc, 32'h4);
    check("t2_iss2", iss_log[2].pc, 32'h8);
    check("t2_iss3", iss_log[3].pc, 32'hC);
    check("t2_back_to_back", iss_cyc[3] - iss_cyc[0], 3);
    check("t2_resume", acc_log[4], 32'h10);

    // Redirect while the request waits for a slow ack.
    do_reset();
    ack_lat = 3;
    tick(0, 1, 32'h100);
    tick(0, 0, 0);
    check("t3_held_syn",  o_syn, 1);
    check("t3_held_addr", o_addr_instr, 32'h0);
    check("t3_flush",     o_count, 0);
    repeat (18) tick(0, 0, 0);
    check("t3_old_acked", acc_log[0], 32'h0);
    check("t3_new_addr",  acc_log[1], 32'h100);
    check("t3_first_iss", iss_log[0], {32'hD3D3D3D3, 32'h100});

    // Redirect coincident with ack.
    do_reset();
    tick(0, 1, 32'h100);
    repeat (6) tick(0, 0, 0);
    check("t4_new_addr",  acc_log[1], 32'h100);
    check("t4_first_iss", iss_log[0], {32'hD3D3D3D3, 32'h100});

    // Fetch PC wraps past the top of the address space.
    do_reset();
    tick(0, 1, 32'hFFFF_FFFC);
    repeat (6) tick(0, 0, 0);
    check("t5_addr_top",  acc_log[1], 32'hFFFF_FFFC);
    check("t5_addr_wrap", acc_log[2], 32'h0);
    check("t5_iss_top",   iss_log[0].pc, 32'hFFFF_FFFC);
    check("t5_iss_wrap",  iss_log[1].pc, 32'h0);

    // Asynchronous reset mid-request with two entries queued.
    do_reset();
    repeat (3) tick(1, 0, 0);
    check("t6_pre_count", o_count, 2);
    check("t6_pre_syn",   o_syn, 1);
    #2;
    f_rst = 1'b1;
    i_ack = 0; change_pc = 0; i_stall = 0;
    #1;
    check("t6_rst_syn",   o_syn, 0);
    check("t6_rst_ce",    o_ce, 0);
    check("t6_rst_count", o_count, 0);
    check("t6_rst_addr",  o_addr_instr, 0);
    clear_logs();
    @(negedge f_clk);
    f_rst = 1'b0;
    repeat (4) tick(0, 0, 0);
    check("t6_restart", acc_log[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage: decouples memory fetch from decode with a DEPTH-entry prefetch FIFO.
- Sits between instruction memory (o_syn/i_ack request-acknowledge handshake) and the decode stage (o_instr/pc/o_ce).
- Supports decode stall back-pressure, PC redirect with queue flush, and discard of an in-flight stale fetch.

Parameters:
- I_WIDTH, 32, instruction width.
- A_WIDTH, 32, memory address width; o_addr_instr is the fetch PC zero-extended or truncated to A_WIDTH.
- PC_WIDTH, 32, program counter width.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- PC_STEP, 4, fetch address increment per instruction.
- RESET_PC, 0, fetch address after reset.

Ports:
- f_clk  input  1  clock, rising edge.
- f_rst  input  1  asynchronous active-high reset.
- o_syn  output  1  memory request valid.
- o_addr_instr  output  A_WIDTH  request address.
- i_ack  input  1  memory acknowledge; i_instr valid this cycle.
- i_instr  input  I_WIDTH  instruction returned by memory.
- change_pc  input  1  redirect request, single-cycle pulse.
- alu_pc_value  input  PC_WIDTH  redirect target.
- i_stall  input  1  decode stall; no instruction issued while high.
- o_instr  output  I_WIDTH  issued instruction.
- pc  output  PC_WIDTH  address of o_instr.
- o_ce  output  1  one-cycle pulse: o_instr/pc newly valid.
- o_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, any cycle, including mid-transaction): o_syn=0, o_addr_instr=RESET_PC, o_instr=0, pc=0, o_ce=0, o_count=0, FSM=IDLE, FIFO cleared, fetch PC=RESET_PC. Any ack arriving after reset is ignored unless a request is outstanding.
- FSM states: IDLE, REQ, DROP.
- IDLE -> REQ when (o_count + pending pushes) < DEPTH and no change_pc this cycle. o_syn rises one cycle after the decision. First request is asserted on the first rising edge after f_rst falls.
- REQ: o_syn=1. o_addr_instr is held stable until i_ack.
  - On i_ack: push {i_instr, fetch PC} into the FIFO, then fetch PC += PC_STEP, modulo 2^PC_WIDTH (wraps to 0).
  - Next state is REQ (back-to-back, new address next cycle) if space remains after the push, else IDLE.
- Redirect in REQ without ack the same cycle: go to DROP. o_syn and the old address stay held until i_ack; that ack's data is discarded (no push). Then load the redirect target and return to REQ.
- Redirect in REQ with i_ack the same cycle: data discarded, fetch PC=alu_pc_value, next state REQ.
- Redirect in IDLE: fetch PC=alu_pc_value.
- Redirect in DROP: target overwritten with the newest alu_pc_value.
- Every redirect clears the FIFO (o_count=0 next cycle) and forces o_ce=0 that cycle; o_instr/pc hold their previous values.
- Issue: when the FIFO is non-empty, i_stall=0 and change_pc=0, pop the head. o_instr/pc are registered and o_ce=1 for one cycle.
  - With i_stall=1: no pop, o_ce=0, o_instr/pc hold.
- Simultaneous push and pop: occupancy unchanged; a push to a full FIFO is impossible because requests are gated by free space.
- Latency: i_ack at edge N -> FIFO write at N -> o_ce high after edge N+1 (empty queue, no stall).
- Throughput: 1 instruction/cycle when memory acks every cycle.
- Unsolicited i_ack (o_syn=0) is ignored.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, i_ack arrives in REQ, i_stall=0 and change_pc=0, the instruction goes directly to o_instr/pc with o_ce=1 after edge N, skipping the FIFO (o_count stays 0). Ack-to-issue latency is 1 cycle.
- Not defined: all instructions pass through the FIFO; ack-to-issue latency is 2 cycles.

Test Plan:
- Reset with RESET_PC=0, ack every cycle with i_instr=A0A0A0A0, B1B1B1B1, C2C2C2C2 -> o_addr_instr 0,4,8 back-to-back; o_ce pulses with pc=0,4,8 in order; latency 2 cycles (1 with FETCH_BYPASS_EN).
- i_stall=1 for 6 cycles, memory acking immediately, DEPTH=4 -> o_count reaches 4, o_syn drops, addresses stop at 0x0C; release stall -> 4 consecutive o_ce with pc 0,4,8,C, then fetching resumes at 0x10.
- change_pc=1, alu_pc_value=0x100, while in REQ with ack delayed 3 cycles -> o_addr_instr held at the old address until ack; that instruction is never issued; next request address is 0x100; FIFO flushed, o_count=0.
- change_pc coincident with i_ack -> acked data dropped; next o_addr_instr=0x100; first issued pc=0x100 with instruction D3D3D3D3.
- Redirect to 0xFFFFFFFC with ack every cycle -> addresses 0xFFFFFFFC then 0x00000000; pc wraps accordingly.
- Assert f_rst asynchronously mid-REQ with 2 entries queued -> o_syn, o_ce, o_count go to 0 immediately (before the next edge); after release, fetch restarts at RESET_PC.
